// File: rtl/main_fsm_pkg.sv
// main_fsm_pkg: state encoding and board helpers for the game sequencer
package main_fsm_pkg;

    typedef enum logic [3:0] {
        S_IDLE         = 4'd0,
        S_PLACE        = 4'd1,
        S_PLACE_WAIT   = 4'd2,
        S_LOAD         = 4'd3,
        S_DECODE       = 4'd4,
        S_ALU          = 4'd5,
        S_ALU_WAIT     = 4'd6,
        S_DISPLAY      = 4'd7,
        S_DISPLAY_WAIT = 4'd8,
        S_LOSE         = 4'd9,
        S_WIN          = 4'd10,
        S_FAULT        = 4'd11
    } state_t;

    function automatic int safe_target(input int rows, input int cols, input int mines);
        return rows * cols - mines;
    endfunction

endpackage

// File: rtl/main_fsm_gen2_wait_watchdog.sv
// main_fsm_gen2_wait_watchdog: cycle counter that flags a stalled wait state
module main_fsm_gen2_wait_watchdog #(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expire
);

    localparam int W = TIMEOUT > 1 ? $clog2(TIMEOUT) : 1;
    localparam logic [W-1:0] LAST = W'(TIMEOUT > 0 ? TIMEOUT - 1 : 0);

    logic [W-1:0] cnt;

    // count cycles spent waiting, parking at the last value
    always_ff @(posedge clk) begin
        if (rst || clr) cnt <= '0;
        else if (en && cnt != LAST) cnt <= cnt + W'(1);
    end

    assign expire = TIMEOUT != 0 && en && cnt == LAST;

endmodule

// File: rtl/main_fsm_gen2.sv
// main_fsm_gen2: game sequencer for placement, load, decode, ALU and display
module main_fsm_gen2
    import main_fsm_pkg::*;
#(
    parameter int ROWS    = 5,
    parameter int COLS    = 5,
    parameter int MINES   = 4,
    parameter int DATA_W  = 5,
    parameter int TIMEOUT = 255,
    parameter int MOVE_W  = 8
) (
    input  logic                               clka,
    input  logic                               restart,
    input  logic                               place,
    input  logic                               place_done,
    input  logic                               data_in,
    input  logic [DATA_W-1:0]                  data,
    input  logic                               decode_done,
    input  logic                               alu_done,
    input  logic                               gameover,
    input  logic [$clog2(ROWS*COLS+1)-1:0]     alu_reveals,
    input  logic                               display_done,
    output logic [3:0]                         state,
    output logic                               start,
    output logic                               load,
    output logic                               decode,
    output logic                               alu,
    output logic                               display,
    output logic [DATA_W-1:0]                  cmd,
    output logic                               flag_mode,
    output logic                               win,
    output logic                               lose,
    output logic                               fault,
    output logic [MOVE_W-1:0]                  move_count
);

    localparam int CELLS = ROWS * COLS;
    localparam int RW = $clog2(CELLS + 1);
    localparam logic [RW:0] CELLS_W = (RW + 1)'(CELLS);
    localparam logic [RW-1:0] TGT = RW'(safe_target(ROWS, COLS, MINES));

    state_t cur, nxt;
    logic pending, in_wait, allowed, pend, accept, expire, unused;
    logic [RW-1:0] revealed, revealed_next;
    logic [RW:0] sum;

    assign unused = decode_done;

    main_fsm_gen2_wait_watchdog #(.TIMEOUT(TIMEOUT)) u_wd (
        .clk(clka), .rst(restart), .clr(!in_wait), .en(in_wait), .expire(expire)
    );

    // input qualification and saturating reveal arithmetic
    always_comb begin
        in_wait = cur inside {S_PLACE_WAIT, S_ALU_WAIT, S_DISPLAY_WAIT};
        allowed = !(cur inside {S_IDLE, S_LOSE, S_WIN, S_FAULT});
        pend = pending | (data_in & allowed);
        accept = data_in & allowed & !pending;
        sum = {1'b0, revealed} + ((gameover || flag_mode) ? '0 : {1'b0, alu_reveals});
        revealed_next = sum >= CELLS_W ? CELLS_W[RW-1:0] : sum[RW-1:0];
    end

    // next-state selection; completed waits take priority over the watchdog
    always_comb begin
        nxt = cur;
        unique case (cur)
            S_IDLE:         nxt = place ? S_PLACE : S_IDLE;
            S_PLACE:        nxt = S_PLACE_WAIT;
            S_PLACE_WAIT:   nxt = (place_done && pend) ? S_LOAD : expire ? S_FAULT : S_PLACE_WAIT;
            S_LOAD:         nxt = S_DECODE;
            S_DECODE:       nxt = S_ALU;
            S_ALU:          nxt = S_ALU_WAIT;
            S_ALU_WAIT:     nxt = alu_done ? (gameover ? S_LOSE : revealed_next >= TGT ? S_WIN : S_DISPLAY)
                                           : expire ? S_FAULT : S_ALU_WAIT;
            S_DISPLAY:      nxt = S_DISPLAY_WAIT;
            S_DISPLAY_WAIT: nxt = (display_done && pend) ? S_LOAD : expire ? S_FAULT : S_DISPLAY_WAIT;
            S_LOSE:         nxt = S_IDLE;
            S_WIN:          nxt = S_IDLE;
            default:        nxt = cur;
        endcase
    end

    // state, command latch, game counters and sticky result flags
    always_ff @(posedge clka) begin
        if (restart) begin
            cur <= S_IDLE;
            pending <= 1'b0;
            cmd <= '0;
            revealed <= '0;
            move_count <= '0;
            win <= 1'b0;
            lose <= 1'b0;
            fault <= 1'b0;
        end else begin
            cur <= nxt;
            pending <= nxt == S_LOAD ? 1'b0 : accept ? 1'b1 : pending;
            if (accept) cmd <= data;
            if (nxt == S_PLACE) begin
                revealed <= '0;
                move_count <= '0;
            end else if (cur == S_ALU_WAIT && alu_done) begin
                revealed <= revealed_next;
                if (move_count != '1) move_count <= move_count + MOVE_W'(1);
            end
            win <= nxt == S_PLACE ? 1'b0 : win | (nxt == S_WIN);
            lose <= nxt == S_PLACE ? 1'b0 : lose | (nxt == S_LOSE);
            fault <= fault | (nxt == S_FAULT);
        end
    end

    assign state = cur;
    assign start = cur == S_PLACE;
    assign load = cur == S_LOAD;
    assign decode = cur == S_DECODE;
    assign alu = cur == S_ALU;
    assign display = cur == S_DISPLAY;
    assign flag_mode = cmd[DATA_W-1];

endmodule

// File: tb/tb_main_fsm_gen2.sv
// tb_main_fsm_gen2: randomized directed game sessions against a move-level model
module tb_main_fsm_gen2;

    localparam int ROWS = 3, COLS = 3, MINES = 1, DATA_W = 5, TIMEOUT = 8, MOVE_W = 8;
    localparam int CELLS = ROWS * COLS;
    localparam int TARGET = CELLS - MINES;

    logic clka = 1'b0;
    logic restart, place, place_done, data_in, decode_done, alu_done, gameover, display_done;
    logic [DATA_W-1:0] data;
    logic [3:0] alu_reveals;
    logic [3:0] state;
    logic start, load, decode, alu, display, flag_mode, win, lose, fault;
    logic [DATA_W-1:0] cmd;
    logic [MOVE_W-1:0] move_count;

    int checks = 0;
    int fails = 0;
    int m_rev, m_moves;
    logic [4:0] m_cmd;
    logic [4:0] c;

    main_fsm_gen2 #(
        .ROWS(ROWS), .COLS(COLS), .MINES(MINES), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT), .MOVE_W(MOVE_W)
    ) dut (
        .clka(clka), .restart(restart), .place(place), .place_done(place_done),
        .data_in(data_in), .data(data), .decode_done(decode_done), .alu_done(alu_done),
        .gameover(gameover), .alu_reveals(alu_reveals), .display_done(display_done),
        .state(state), .start(start), .load(load), .decode(decode), .alu(alu),
        .display(display), .cmd(cmd), .flag_mode(flag_mode), .win(win), .lose(lose),
        .fault(fault), .move_count(move_count)
    );

    always #5 clka = ~clka;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "bench time limit");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clka);
        #1;
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_state"}, state, 0);
        chk({tag, "_flags"}, {start, load, decode, alu, display, flag_mode, win, lose, fault}, 0);
        chk({tag, "_cmd"}, cmd, 0);
        chk({tag, "_moves"}, move_count, 0);
    endtask

    task automatic new_game;
        place = 1'b1;
        tick;
        place = 1'b0;
        m_rev = 0;
        m_moves = 0;
        chk("place_state", state, 1);
        chk("start", start, 1);
        chk("place_clear", {win, lose, move_count}, 0);
        tick;
        chk("place_wait", {state, start}, {4'd2, 1'b0});
    endtask

    task automatic to_alu(input logic [4:0] cv, input int lead, input bit dup, input int ws);
        for (int i = 0; i <= lead; i++) begin
            data_in = (i == 0) || (dup && i == 1);
            data = (i == 0) ? cv : ~cv;
            place_done = (i == lead);
            display_done = (i == lead);
            tick;
            if (i < lead) chk("wait_hold", state, ws);
        end
        data_in = 1'b0;
        place_done = 1'b0;
        display_done = 1'b0;
        m_cmd = cv;
        chk("load_state", {state, load}, {4'd3, 1'b1});
        chk("cmd", cmd, cv);
        chk("flag_mode", flag_mode, cv[4]);
        tick;
        chk("decode", {state, load, decode, alu}, {4'd4, 3'b010});
        tick;
        chk("alu", {state, decode, alu}, {4'd5, 2'b01});
        tick;
        chk("alu_wait", {state, alu}, {4'd6, 1'b0});
    endtask

    task automatic finish_move(input int aw, input int rv, input bit go);
        int exp;
        for (int i = 0; i < aw; i++) begin
            tick;
            chk("alu_hold", state, 6);
        end
        alu_done = 1'b1;
        gameover = go;
        alu_reveals = 4'(rv);
        if (!go && !m_cmd[4]) m_rev = (m_rev + rv > CELLS) ? CELLS : m_rev + rv;
        m_moves++;
        exp = go ? 9 : (m_rev >= TARGET ? 10 : 7);
        tick;
        alu_done = 1'b0;
        gameover = 1'b0;
        alu_reveals = '0;
        chk("alu_exit", state, exp);
        chk("moves", move_count, m_moves);
        if (exp == 7) begin
            chk("display", display, 1);
            tick;
            chk("display_wait", {state, display}, {4'd8, 1'b0});
        end else begin
            chk("result", {win, lose}, exp == 10 ? 2'b10 : 2'b01);
            tick;
            chk("back_idle", state, 0);
            chk("result_sticky", {win, lose}, exp == 10 ? 2'b10 : 2'b01);
        end
    endtask

    initial begin
        {restart, place, place_done, data_in, decode_done, alu_done, gameover, display_done} = '0;
        data = '0;
        alu_reveals = '0;
        restart = 1'b1;
        repeat (3) tick;
        restart = 1'b0;
        check_zero("reset");
        data_in = 1'b1;
        data = 5'h05;
        tick;
        data_in = 1'b0;
        chk("idle_hold", state, 0);

        new_game;
        to_alu(5'h07, 1, 1'b0, 2);
        finish_move($urandom_range(0, 6), 3, 1'b0);
        c = 5'($urandom_range(1, 8));
        to_alu(c, 3, 1'b1, 8);
        finish_move($urandom_range(0, 6), 3, 1'b0);
        c = 5'($urandom_range(0, 8));
        to_alu(c, $urandom_range(0, 5), 1'b0, 8);
        finish_move(7, 2, 1'b0);
        chk("win_moves", move_count, 3);

        new_game;
        place_done = 1'b1;
        tick;
        place_done = 1'b0;
        chk("no_pending", state, 2);
        c = 5'($urandom_range(0, 8));
        to_alu(c, $urandom_range(0, 5), 1'b0, 2);
        finish_move($urandom_range(0, 6), $urandom_range(1, 2), 1'b0);
        to_alu(5'h12, 4, 1'b0, 8);
        finish_move($urandom_range(0, 6), 7, 1'b0);
        c = 5'($urandom_range(0, 8));
        to_alu(c, $urandom_range(0, 5), 1'b0, 8);
        finish_move($urandom_range(0, 6), 9, 1'b1);

        new_game;
        c = 5'($urandom_range(0, 8));
        to_alu(c, $urandom_range(0, 5), 1'b0, 2);
        for (int i = 0; i < 7; i++) begin
            tick;
            chk("fault_hold", {state, fault}, {4'd6, 1'b0});
        end
        tick;
        chk("fault_state", {state, fault}, {4'd11, 1'b1});
        place = 1'b1;
        data_in = 1'b1;
        alu_done = 1'b1;
        tick;
        {place, data_in, alu_done} = '0;
        chk("fault_stuck", {state, fault}, {4'd11, 1'b1});
        restart = 1'b1;
        tick;
        restart = 1'b0;
        check_zero("fault_reset");

        new_game;
        for (int i = 0; i < 7; i++) begin
            tick;
            chk("pw_hold", state, 2);
        end
        tick;
        chk("pw_fault", {state, fault}, {4'd11, 1'b1});
        restart = 1'b1;
        tick;
        restart = 1'b0;
        check_zero("pw_reset");

        new_game;
        c = 5'($urandom_range(1, 8));
        to_alu(c, $urandom_range(0, 5), 1'b0, 2);
        finish_move($urandom_range(0, 6), 1, 1'b0);
        c = 5'($urandom_range(1, 8));
        to_alu(c, $urandom_range(0, 5), 1'b0, 8);
        repeat (4) tick;
        restart = 1'b1;
        tick;
        restart = 1'b0;
        check_zero("mid_reset");

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
